id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register of the 5-stage MIPS core. It sits between the decode stage (register file, sign extender, control unit) and the execute stage. On each CLK rising edge it captures operand data, the immediate, control signals, register specifiers, funct and the next PC. It holds all contents while the memory system reports a miss (hit=0).

Parameters:
- DATA_W, default 32, width of readData1/readData2/signExImmediate/nextPc paths.

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- hit  in  1  pipeline advance enable: 1 = load new values, 0 = stall/hold
- readData1  in  DATA_W  register file read port 1 (rs value)
- readData2  in  DATA_W  register file read port 2 (rt value)
- signExImmediate  in  DATA_W  sign-extended 16-bit immediate
- regDst  in  1  destination select (1 = rd, 0 = rt)
- aluSrc  in  1  ALU operand B select (1 = immediate)
- memToReg  in  1  writeback select (1 = memory data)
- regWrite  in  1  register file write enable
- memRead  in  1  data memory read enable
- memWrite  in  1  data memory write enable
- branch  in  1  branch instruction flag
- aluOp  in  3  ALU operation class from the control unit
- rt  in  5  rt field
- rd  in  5  rd field
- funct  in  6  funct field
- nextPc  in  DATA_W  PC+4 of the instruction
- readData1Out, readData2Out, signExImmediateOut, regDstOut, aluSrcOut, memToRegOut, regWriteOut, memReadOut, memWriteOut, branchOut, aluOpOut, rtOut, rdOut, functOut, nextPcOut  out  same width as the matching input  registered copies

Behaviour:
- Every output is driven directly from a flop; there is no combinational input-to-output path.
- Priority at each CLK rising edge: reset, then (optional) flush, then hit.
- reset=1: all outputs go to 0, all bits. This yields a NOP bubble, since all write and memory enables are 0. The hit input is ignored.
- reset=0, hit=1: every output takes its corresponding input value. Latency is exactly one cycle.
- reset=0, hit=0: every output holds its previous value. Inputs are ignored.
- Power-up, before the first reset: outputs are undefined in simulation (X). No initial blocks are used in synthesizable RTL.
- Values pass through unmodified. No sign extension, truncation or arithmetic happens in this block.
- All fields are captured or held as a group. No field may update independently of the others.
- Reset asserted while hit=0: reset wins, and outputs are cleared.
- hit toggling every cycle: outputs change only on edges where hit=1.

Optional Feature:
- Macro: ID_EX_FLUSH_EN
- When defined, adds input port "flush" (1 bit, active-high, synchronous).
- Effect of reset=0, flush=1 at a CLK edge:
  - Control outputs are cleared to 0: regDstOut, aluSrcOut, memToRegOut, regWriteOut, memReadOut, memWriteOut, branchOut, aluOpOut.
  - This applies regardless of hit.
  - Data and field outputs follow the normal hit rule.
- When undefined:
  - No flush port exists.
  - Behaviour is exactly the base behaviour above.

Test Plan:
- Reset clear: drive all inputs to nonzero values (readData1=32'hDEADBEEF, aluOp=3'b111, rt=5'd31, etc.) with reset=1 for one edge -> every output is 0.
- Normal load: reset=0, hit=1, readData1=32'h11111111, readData2=32'h22222222, signExImmediate=32'hFFFFFFF0, regWrite=1, aluOp=3'b010, rt=5, rd=10, funct=6'h20, nextPc=32'h4 -> after one edge, outputs equal these values. Before the edge, outputs are unchanged.
- Stall hold: load as above, then set hit=0 and change all inputs (readData1=32'hAAAAAAAA, memWrite=1) for 3 edges -> outputs keep the earlier values. Setting hit=1 loads the new values on the next edge.
- Reset during stall: hit=0 with outputs nonzero, assert reset for one edge -> all outputs 0.
- Per-bit control pass: walk a single 1 through regDst, aluSrc, memToReg, regWrite, memRead, memWrite, branch with hit=1 -> exactly the matching Out bit is 1 after each edge.
- (ID_EX_FLUSH_EN) flush=1, hit=1, regWrite=1, readData1=32'h5 -> regWriteOut=0 and readData1Out=32'h5.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
//==============================================================================
// Module   : id_ex_pipe_reg
// Brief    : ID/EX pipeline register. It captures the decode-stage operands,
//            controls and fields on hit=1 and holds them on a memory miss.
//            Optional macro ID_EX_FLUSH_EN adds a flush input that turns the
//            control group into a bubble.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module id_ex_pipe_reg #(
   parameter int DATA_W = 32
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              hit,
`ifdef ID_EX_FLUSH_EN
   input  logic              flush,
`endif
   input  logic [DATA_W-1:0] readData1,
   input  logic [DATA_W-1:0] readData2,
   input  logic [DATA_W-1:0] signExImmediate,
   input  logic              regDst,
   input  logic              aluSrc,
   input  logic              memToReg,
   input  logic              regWrite,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic              branch,
   input  logic [2:0]        aluOp,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [5:0]        funct,
   input  logic [DATA_W-1:0] nextPc,
   output logic [DATA_W-1:0] readData1Out,
   output logic [DATA_W-1:0] readData2Out,
   output logic [DATA_W-1:0] signExImmediateOut,
   output logic              regDstOut,
   output logic              aluSrcOut,
   output logic              memToRegOut,
   output logic              regWriteOut,
   output logic              memReadOut,
   output logic              memWriteOut,
   output logic              branchOut,
   output logic [2:0]        aluOpOut,
   output logic [4:0]        rtOut,
   output logic [4:0]        rdOut,
   output logic [5:0]        functOut,
   output logic [DATA_W-1:0] nextPcOut
);

   always_ff @(posedge CLK) begin
      if (reset) begin
         readData1Out       <= '0;
         readData2Out       <= '0;
         signExImmediateOut <= '0;
         regDstOut          <= 1'b0;
         aluSrcOut          <= 1'b0;
         memToRegOut        <= 1'b0;
         regWriteOut        <= 1'b0;
         memReadOut         <= 1'b0;
         memWriteOut        <= 1'b0;
         branchOut          <= 1'b0;
         aluOpOut           <= '0;
         rtOut              <= '0;
         rdOut              <= '0;
         functOut           <= '0;
         nextPcOut          <= '0;
      end else begin
         if (hit) begin
            readData1Out       <= readData1;
            readData2Out       <= readData2;
            signExImmediateOut <= signExImmediate;
            regDstOut          <= regDst;
            aluSrcOut          <= aluSrc;
            memToRegOut        <= memToReg;
            regWriteOut        <= regWrite;
            memReadOut         <= memRead;
            memWriteOut        <= memWrite;
            branchOut          <= branch;
            aluOpOut           <= aluOp;
            rtOut              <= rt;
            rdOut              <= rd;
            functOut           <= funct;
            nextPcOut          <= nextPc;
         end
`ifdef ID_EX_FLUSH_EN
         // Later assignments override the load, so a flush bubbles the
         // controls even during a stall, while the data fields follow hit.
         if (flush) begin
            regDstOut   <= 1'b0;
            aluSrcOut   <= 1'b0;
            memToRegOut <= 1'b0;
            regWriteOut <= 1'b0;
            memReadOut  <= 1'b0;
            memWriteOut <= 1'b0;
            branchOut   <= 1'b0;
            aluOpOut    <= '0;
         end
`endif
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
//==============================================================================
// Module   : tb_id_ex_pipe_reg
// Brief    : Self-checking bench for id_ex_pipe_reg. It uses directed cases
//            plus random traffic against a field-level reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_id_ex_pipe_reg;

   typedef struct packed {
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic        regDst;
      logic        aluSrc;
      logic        memToReg;
      logic        regWrite;
      logic        memRead;
      logic        memWrite;
      logic        branch;
      logic [2:0]  aluOp;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [5:0]  funct;
      logic [31:0] pc;
   } bundle_t;

   localparam int c_BW = $bits(bundle_t);

   logic        CLK;
   logic        reset;
   logic        hit;
`ifdef ID_EX_FLUSH_EN
   logic        flush;
`endif
   logic [31:0] readData1, readData2, signExImmediate, nextPc;
   logic        regDst, aluSrc, memToReg, regWrite, memRead, memWrite, branch;
   logic [2:0]  aluOp;
   logic [4:0]  rt, rd;
   logic [5:0]  funct;

   logic [31:0] readData1Out, readData2Out, signExImmediateOut, nextPcOut;
   logic        regDstOut, aluSrcOut, memToRegOut, regWriteOut;
   logic        memReadOut, memWriteOut, branchOut;
   logic [2:0]  aluOpOut;
   logic [4:0]  rtOut, rdOut;
   logic [5:0]  functOut;

   bundle_t obs;
   bundle_t model;
   int      vectors;
   int      miscompares;

   assign obs = {readData1Out, readData2Out, signExImmediateOut,
                 regDstOut, aluSrcOut, memToRegOut, regWriteOut,
                 memReadOut, memWriteOut, branchOut, aluOpOut,
                 rtOut, rdOut, functOut, nextPcOut};

   id_ex_pipe_reg #(.DATA_W(32)) dut (
      .CLK               (CLK),
      .reset             (reset),
      .hit               (hit),
`ifdef ID_EX_FLUSH_EN
      .flush             (flush),
`endif
      .readData1         (readData1),
      .readData2         (readData2),
      .signExImmediate   (signExImmediate),
      .regDst            (regDst),
      .aluSrc            (aluSrc),
      .memToReg          (memToReg),
      .regWrite          (regWrite),
      .memRead           (memRead),
      .memWrite          (memWrite),
      .branch            (branch),
      .aluOp             (aluOp),
      .rt                (rt),
      .rd                (rd),
      .funct             (funct),
      .nextPc            (nextPc),
      .readData1Out      (readData1Out),
      .readData2Out      (readData2Out),
      .signExImmediateOut(signExImmediateOut),
      .regDstOut         (regDstOut),
      .aluSrcOut         (aluSrcOut),
      .memToRegOut       (memToRegOut),
      .regWriteOut       (regWriteOut),
      .memReadOut        (memReadOut),
      .memWriteOut       (memWriteOut),
      .branchOut         (branchOut),
      .aluOpOut          (aluOpOut),
      .rtOut             (rtOut),
      .rdOut             (rdOut),
      .functOut          (functOut),
      .nextPcOut         (nextPcOut)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic checkVal(input string tag, input logic [c_BW-1:0] got,
                           input logic [c_BW-1:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // Reference behaviour: reset clears everything, otherwise hit loads the
   // whole group, and a flush zeroes the control fields.
   function automatic bundle_t nextState(bundle_t cur, bundle_t in, logic r,
                                         logic h, logic f);
      bundle_t n;
      if (r) return '0;
      n = h ? in : cur;
      if (f) begin
         n.regDst = 0; n.aluSrc = 0; n.memToReg = 0; n.regWrite = 0;
         n.memRead = 0; n.memWrite = 0; n.branch = 0; n.aluOp = 0;
      end
      return n;
   endfunction

   task automatic step(input string tag, input bundle_t s, input logic r,
                       input logic h, input logic f);
      readData1 = s.rd1;  readData2 = s.rd2;  signExImmediate = s.imm;
      regDst = s.regDst;  aluSrc = s.aluSrc;  memToReg = s.memToReg;
      regWrite = s.regWrite; memRead = s.memRead; memWrite = s.memWrite;
      branch = s.branch;  aluOp = s.aluOp;    rt = s.rt;  rd = s.rd;
      funct = s.funct;    nextPc = s.pc;
      reset = r;          hit = h;
`ifdef ID_EX_FLUSH_EN
      flush = f;
`endif
      #1;
      checkVal({tag, "-preedge"}, obs, model);
      @(posedge CLK);
`ifdef ID_EX_FLUSH_EN
      model = nextState(model, s, r, h, f);
`else
      model = nextState(model, s, r, h, 1'b0);
`endif
      #1;
      checkVal(tag, obs, model);
   endtask

   function automatic bundle_t randBundle();
      bundle_t b;
      b = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return b;
   endfunction

   bundle_t s;
   bundle_t z;

   initial begin
      vectors = 0;
      miscompares = 0;
      model = 'x;
      z = '0;

      // Reset with every input nonzero.
      s = '1;
      s.rd1 = 32'hDEADBEEF; s.aluOp = 3'b111; s.rt = 5'd31;
      step("reset_clear", s, 1'b1, 1'b1, 1'b0);
      checkVal("reset_all_zero", obs, '0);

      // Normal load.
      s = '0;
      s.rd1 = 32'h11111111; s.rd2 = 32'h22222222; s.imm = 32'hFFFFFFF0;
      s.regWrite = 1'b1; s.aluOp = 3'b010; s.rt = 5'd5; s.rd = 5'd10;
      s.funct = 6'h20; s.pc = 32'h4;
      step("normal_load", s, 1'b0, 1'b1, 1'b0);
      checkVal("normal_load_rd1", {{(c_BW-32){1'b0}}, readData1Out},
               {{(c_BW-32){1'b0}}, 32'h11111111});

      // Stall for three edges with changed inputs, then release.
      s.rd1 = 32'hAAAAAAAA; s.memWrite = 1'b1;
      for (int i = 0; i < 3; i++) step("stall_hold", s, 1'b0, 1'b0, 1'b0);
      checkVal("stall_rd1", {{(c_BW-32){1'b0}}, readData1Out},
               {{(c_BW-32){1'b0}}, 32'h11111111});
      step("stall_release", s, 1'b0, 1'b1, 1'b0);
      checkVal("release_memWrite", {{(c_BW-1){1'b0}}, memWriteOut},
               {{(c_BW-1){1'b0}}, 1'b1});

      // Reset during a stall.
      step("reset_in_stall", randBundle(), 1'b1, 1'b0, 1'b0);
      checkVal("reset_in_stall_zero", obs, '0);

      // Walk a single one through the 1-bit controls.
      for (int k = 0; k < 7; k++) begin
         s = z;
         {s.regDst, s.aluSrc, s.memToReg, s.regWrite, s.memRead,
          s.memWrite, s.branch} = 7'b1000000 >> k;
         step("ctrl_walk", s, 1'b0, 1'b1, 1'b0);
         checkVal("ctrl_walk_bits",
                  {{(c_BW-7){1'b0}}, regDstOut, aluSrcOut, memToRegOut,
                   regWriteOut, memReadOut, memWriteOut, branchOut},
                  {{(c_BW-7){1'b0}}, 7'b1000000 >> k});
      end

      // hit toggling every cycle with fresh data.
      for (int i = 0; i < 8; i++)
         step("hit_toggle", randBundle(), 1'b0, i[0], 1'b0);

`ifdef ID_EX_FLUSH_EN
      s = z; s.regWrite = 1'b1; s.rd1 = 32'h5;
      step("flush_hit", s, 1'b0, 1'b1, 1'b1);
      checkVal("flush_regWrite", {{(c_BW-1){1'b0}}, regWriteOut}, '0);
      checkVal("flush_rd1", {{(c_BW-32){1'b0}}, readData1Out},
               {{(c_BW-32){1'b0}}, 32'h5});
      step("flush_stall", randBundle(), 1'b0, 1'b0, 1'b1);
`endif

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         step("random", randBundle(), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
